// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard fields, memory handshake and control/statistics outputs of the pipeline controller.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic [REG_W-1:0] ex_dest;
    logic [REG_W-1:0] mem_dest;
    logic             id_use_src1;
    logic             id_two_src;
    logic             ex_wb_en;
    logic             ex_mem_read;
    logic             mem_wb_en;
    logic             fwd_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             freeze_pc;
    logic             freeze_ifid;
    logic             flush_ifid;
    logic             flush_idex;
    logic             freeze_all;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        output id_src1, id_src2, ex_dest, mem_dest, id_use_src1, id_two_src,
               ex_wb_en, ex_mem_read, mem_wb_en, fwd_en, branch_taken, mem_req, mem_ready,
        input  freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_all, mem_timeout,
               stall_cnt, flush_cnt, wait_cnt
    );

    modport slave (
        input  id_src1, id_src2, ex_dest, mem_dest, id_use_src1, id_two_src,
               ex_wb_en, ex_mem_read, mem_wb_en, fwd_en, branch_taken, mem_req, mem_ready,
        output freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_all, mem_timeout,
               stall_cnt, flush_cnt, wait_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// RAW hazard detection between the ID instruction and the EX/MEM destinations.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             fwd_en,
    output logic             hazard
);

    logic hz_ex;
    logic hz_mem;

    assign hz_ex  = ex_wb_en  & ((id_use_src1 & (ex_dest  == id_src1)) |
                                 (id_two_src  & (ex_dest  == id_src2)));
    assign hz_mem = mem_wb_en & ((id_use_src1 & (mem_dest == id_src1)) |
                                 (id_two_src  & (mem_dest == id_src2)));

    // With forwarding only a load in EX cannot be bypassed in time.
    assign hazard = fwd_en ? (hz_ex & ex_mem_read) : (hz_ex | hz_mem);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing: post-reset hold, hazard stall, branch kill, memory wait with watchdog.
//   state       | meaning
//   ST_INIT     | post-reset hold, whole pipeline frozen
//   ST_RUN      | normal flow, stall/kill decided per cycle
//   ST_MEM_WAIT | data memory busy, pipeline frozen until mem_ready
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 2,
    parameter int MAX_WAIT    = 255,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WD_W   = $clog2(MAX_WAIT + 2);
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(MAX_WAIT);

    state_t            state, state_nxt;
    logic [INIT_W-1:0] init_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_now;
    logic              hazard;
    logic              run_rules;
    logic              freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_all;
    logic              mem_timeout;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt, wait_cnt;

    hazard_detect u_hazard (
        .id_src1     (bus.id_src1),
        .id_src2     (bus.id_src2),
        .id_use_src1 (bus.id_use_src1),
        .id_two_src  (bus.id_two_src),
        .ex_dest     (bus.ex_dest),
        .ex_wb_en    (bus.ex_wb_en),
        .ex_mem_read (bus.ex_mem_read),
        .mem_dest    (bus.mem_dest),
        .mem_wb_en   (bus.mem_wb_en),
        .fwd_en      (bus.fwd_en),
        .hazard      (hazard)
    );

    // A completing wait falls straight through to the RUN rules in the same cycle.
    assign run_rules = (state == ST_RUN) || ((state == ST_MEM_WAIT) && bus.mem_ready);

    always_comb begin
        state_nxt   = state;
        freeze_pc   = 1'b0;
        freeze_ifid = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        freeze_all  = 1'b0;
        unique case (state)
            ST_INIT: begin
                freeze_all = 1'b1;
                if (init_cnt == '0) state_nxt = ST_RUN;
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (run_rules) begin
                    state_nxt = ST_RUN;
                    if (bus.mem_req && !bus.mem_ready) begin
                        freeze_all = 1'b1;
                        state_nxt  = ST_MEM_WAIT;
                    end else if (bus.branch_taken) begin
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else if (hazard) begin
                        freeze_pc   = 1'b1;
                        freeze_ifid = 1'b1;
                        flush_idex  = 1'b1;
                    end
                end else begin
                    freeze_all = 1'b1;
                end
            end
            default: begin
                freeze_all = 1'b1;
                state_nxt  = ST_INIT;
            end
        endcase
    end

    // Ordinal of the current wait cycle within the ongoing memory access.
    assign wd_now = (state == ST_MEM_WAIT) ? wd_cnt + 1'b1 : WD_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_INIT;
            init_cnt    <= INIT_LOAD;
            wd_cnt      <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT && init_cnt != '0) init_cnt <= init_cnt - 1'b1;
            if (freeze_all && state != ST_INIT) begin
                wd_cnt <= (wd_now >= WD_LIMIT) ? WD_LIMIT : wd_now;
                if (wd_now == WD_LIMIT) mem_timeout <= 1'b1;
                if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
            end
            if (freeze_pc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_ifid && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.freeze_pc   = freeze_pc;
    assign bus.freeze_ifid = freeze_ifid;
    assign bus.flush_ifid  = flush_ifid;
    assign bus.flush_idex  = flush_idex;
    assign bus.freeze_all  = freeze_all;
    assign bus.mem_timeout = mem_timeout;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
    assign bus.wait_cnt    = wait_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_pipeline_ctrl;
    localparam int INIT_CYCLES = 2;
    localparam int MAX_WAIT    = 8;
    localparam int CNT_W       = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks   = 0;
    int failures = 0;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(
        .INIT_CYCLES (INIT_CYCLES),
        .MAX_WAIT    (MAX_WAIT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: counts of remaining hold cycles and of the ongoing wait, plus statistics.
    int m_init_left = INIT_CYCLES;
    bit m_waiting   = 1'b0;
    int m_wait_run  = 0;
    bit m_timeout   = 1'b0;
    int m_stall     = 0;
    int m_flush     = 0;
    int m_wait      = 0;

    function automatic bit model_hazard();
        bit hz_ex, hz_mem;
        hz_ex  = bus.ex_wb_en  && ((bus.id_use_src1 && bus.ex_dest  == bus.id_src1) ||
                                   (bus.id_two_src  && bus.ex_dest  == bus.id_src2));
        hz_mem = bus.mem_wb_en && ((bus.id_use_src1 && bus.mem_dest == bus.id_src1) ||
                                   (bus.id_two_src  && bus.mem_dest == bus.id_src2));
        return bus.fwd_en ? (hz_ex && bus.ex_mem_read) : (hz_ex || hz_mem);
    endfunction

    // {freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_all}
    function automatic logic [4:0] model_ctrl();
        if (m_init_left > 0) return 5'b00001;
        if (!bus.mem_ready && (m_waiting || bus.mem_req)) return 5'b00001;
        if (bus.branch_taken) return 5'b00110;
        if (model_hazard()) return 5'b11010;
        return 5'b00000;
    endfunction

    function automatic void model_edge();
        logic [4:0] c;
        if (!rst) begin
            m_init_left = INIT_CYCLES;
            m_waiting   = 1'b0;
            m_wait_run  = 0;
            m_timeout   = 1'b0;
            m_stall     = 0;
            m_flush     = 0;
            m_wait      = 0;
        end else if (m_init_left > 0) begin
            m_init_left--;
        end else begin
            c = model_ctrl();
            if (c[0]) begin
                m_wait_run++;
                if (m_wait_run == MAX_WAIT) m_timeout = 1'b1;
                m_waiting = 1'b1;
                if (m_wait < CNT_MAX) m_wait++;
            end else begin
                m_waiting  = 1'b0;
                m_wait_run = 0;
            end
            if (c[4] && m_stall < CNT_MAX) m_stall++;
            if (c[2] && m_flush < CNT_MAX) m_flush++;
        end
    endfunction

    function automatic logic [4:0] ctrl_now();
        return {bus.freeze_pc, bus.freeze_ifid, bus.flush_ifid, bus.flush_idex, bus.freeze_all};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_src1      = '0;
        bus.id_src2      = '0;
        bus.ex_dest      = '0;
        bus.mem_dest     = '0;
        bus.id_use_src1  = 1'b0;
        bus.id_two_src   = 1'b0;
        bus.ex_wb_en     = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.mem_wb_en    = 1'b0;
        bus.fwd_en       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        for (int k = 0; k < INIT_CYCLES; k++) begin
            @(negedge clk);
            checks++;
            if (ctrl_now() !== 5'b00001) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: got %b want 00001", k, ctrl_now());
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (ctrl_now() !== 5'b00000) begin
            failures++;
            $display("FAIL reset_run_outputs: got %b want 00000", ctrl_now());
        end
        checks++;
        if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0 || bus.wait_cnt !== '0 || bus.mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d wait=%0d timeout=%b want 0 0 0 0",
                     bus.stall_cnt, bus.flush_cnt, bus.wait_cnt, bus.mem_timeout);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        bus.fwd_en = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_wb_en = 1'b1;
        bus.ex_dest = 4'd3; bus.id_src1 = 4'd3; bus.id_use_src1 = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== 5'b11010) begin
            failures++;
            $display("FAIL load_use_stall: got %b want 11010", ctrl_now());
        end
        tick();
        bus.ex_wb_en = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_dest = 4'd0;
        bus.mem_dest = 4'd3; bus.mem_wb_en = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== 5'b00000) begin
            failures++;
            $display("FAIL load_use_release: got %b want 00000", ctrl_now());
        end
        checks++;
        if (bus.stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL load_use_stall_cnt: got %0d want 1", bus.stall_cnt);
        end
        tick();
    endtask

    task automatic test_branch_over_hazard();
        idle_inputs();
        bus.mem_dest = 4'd5; bus.mem_wb_en = 1'b1; bus.id_two_src = 1'b1; bus.id_src2 = 4'd5;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== 5'b11010) begin
            failures++;
            $display("FAIL nofwd_mem_stall: got %b want 11010", ctrl_now());
        end
        bus.branch_taken = 1'b1;
        #1;
        checks++;
        if (ctrl_now() !== 5'b00110) begin
            failures++;
            $display("FAIL branch_over_hazard: got %b want 00110", ctrl_now());
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.flush_cnt !== 16'd1 || bus.stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL branch_counts: got flush=%0d stall=%0d want flush=1 stall=1",
                     bus.flush_cnt, bus.stall_cnt);
        end
        tick();
    endtask

    task automatic test_mem_wait_branch();
        idle_inputs();
        bus.mem_req = 1'b1; bus.branch_taken = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (ctrl_now() !== 5'b00001) begin
                failures++;
                $display("FAIL mem_wait_freeze cycle %0d: got %b want 00001", k, ctrl_now());
            end
            tick();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== 5'b00110) begin
            failures++;
            $display("FAIL mem_ready_deferred_branch: got %b want 00110", ctrl_now());
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.wait_cnt !== 16'd4 || bus.flush_cnt !== 16'd2 || bus.mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL mem_wait_counts: got wait=%0d flush=%0d timeout=%b want wait=4 flush=2 timeout=0",
                     bus.wait_cnt, bus.flush_cnt, bus.mem_timeout);
        end
        tick();
    endtask

    task automatic test_timeout();
        idle_inputs();
        bus.mem_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (bus.freeze_all !== 1'b1 || bus.mem_timeout !== (k > MAX_WAIT)) begin
                failures++;
                $display("FAIL timeout_wait cycle %0d: got freeze_all=%b timeout=%b want 1 %b",
                         k, bus.freeze_all, bus.mem_timeout, (k > MAX_WAIT));
            end
            tick();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== 5'b00000) begin
            failures++;
            $display("FAIL timeout_ready_cycle: got %b want 00000", ctrl_now());
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.mem_timeout !== 1'b1 || bus.wait_cnt !== 16'd14) begin
            failures++;
            $display("FAIL timeout_sticky: got timeout=%b wait=%0d want 1 14", bus.mem_timeout, bus.wait_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        bus.mem_req = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (ctrl_now() !== 5'b00001 || bus.mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wait_state: got ctrl=%b timeout=%b want 00001 0", ctrl_now(), bus.mem_timeout);
        end
        checks++;
        if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0 || bus.wait_cnt !== '0) begin
            failures++;
            $display("FAIL reset_mid_wait_counters: got stall=%0d flush=%0d wait=%0d want 0 0 0",
                     bus.stall_cnt, bus.flush_cnt, bus.wait_cnt);
        end
        idle_inputs();
        rst = 1'b1;
        repeat (INIT_CYCLES) tick();
        @(negedge clk);
        checks++;
        if (ctrl_now() !== 5'b00000) begin
            failures++;
            $display("FAIL reset_mid_wait_rerun: got %b want 00000", ctrl_now());
        end
        tick();
    endtask

    task automatic test_random();
        logic [4:0] exp_ctrl;
        for (int c = 0; c < 3000; c++) begin
            rst              = ($urandom_range(0, 199) != 0);
            bus.id_src1      = 4'($urandom_range(0, 3));
            bus.id_src2      = 4'($urandom_range(0, 3));
            bus.ex_dest      = 4'($urandom_range(0, 3));
            bus.mem_dest     = 4'($urandom_range(0, 3));
            bus.id_use_src1  = 1'($urandom_range(0, 1));
            bus.id_two_src   = 1'($urandom_range(0, 1));
            bus.ex_wb_en     = 1'($urandom_range(0, 1));
            bus.ex_mem_read  = 1'($urandom_range(0, 1));
            bus.mem_wb_en    = 1'($urandom_range(0, 1));
            bus.fwd_en       = 1'($urandom_range(0, 1));
            bus.branch_taken = ($urandom_range(0, 4) == 0);
            bus.mem_req      = ($urandom_range(0, 3) == 0);
            bus.mem_ready    = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            exp_ctrl = model_ctrl();
            checks++;
            if (ctrl_now() !== exp_ctrl) begin
                failures++;
                $display("FAIL random_ctrl cycle %0d: got %b want %b", c, ctrl_now(), exp_ctrl);
            end
            checks++;
            if (bus.stall_cnt !== CNT_W'(m_stall) || bus.flush_cnt !== CNT_W'(m_flush) ||
                bus.wait_cnt !== CNT_W'(m_wait) || bus.mem_timeout !== m_timeout) begin
                failures++;
                $display("FAIL random_stats cycle %0d: got stall=%0d flush=%0d wait=%0d timeout=%b want %0d %0d %0d %b",
                         c, bus.stall_cnt, bus.flush_cnt, bus.wait_cnt, bus.mem_timeout,
                         m_stall, m_flush, m_wait, m_timeout);
            end
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_over_hazard();
        test_mem_wait_branch();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got simulation still running want finished");
        $fatal(1, "time limit reached");
    end

endmodule
